decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised, registered binary-to-one-hot decoder with enable and an auto-scan mode. In direct mode it registers the one-hot decode of `x`. In scan mode it rotates the active output through all 2^W positions at a programmable rate. It drives multiplexed display digit selects and other time-shared enables in the npc peripheral area, and replaces fixed-width combinational decoders there.

## Interface
- `W`, 2: select width; outputs N = 2^W (localparam); legal W ≥ 1
- `DIV`, 4: clock cycles per scan step; legal DIV ≥ 1
- `ACTIVE_LOW`, 0: 1 = output active level is 0 (all inactive = all ones)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `en` in 1: 1 = decoder active; 0 = all outputs inactive
- `mode` in 1: 0 = direct decode of `x`; 1 = auto-scan
- `x` in W: direct-mode select; start index on entry to scan
- `y` out N: one-hot (or one-cold if ACTIVE_LOW) select, driven from flops
- `idx` out W: index currently asserted on `y`
- `step` out 1: one-cycle pulse on the cycle `idx` advanced in scan mode

## Operation
- States: IDLE, DIRECT, SCAN (2-bit encoding). Next state is evaluated every edge:
  - `en`=0 → IDLE
  - `en`=1, `mode`=0 → DIRECT
  - `en`=1, `mode`=1 → SCAN
- IDLE: `y` is all inactive. `idx` holds its value. Divider count is cleared. `step`=0.
- DIRECT: `idx` ← `x` and `y` ← onehot(`x`) every cycle. Divider count is cleared. `step`=0.
- Entry to SCAN (previous state not SCAN): `idx` ← `x`, `y` ← onehot(`x`), divider count ← 0. No `step` pulse.
- In SCAN: the divider count increments each cycle.
  - When count = DIV−1: count ← 0, `idx` ← `idx`+1 modulo N (N−1 wraps to 0), `y` follows, and `step`=1 for that cycle.
  - Otherwise `idx` and `y` hold.
- DIV=1: `idx` advances every cycle in SCAN, and `step` stays high continuously.
- `x` is ignored while in SCAN, except on the entry cycle.
- SCAN→DIRECT or SCAN→IDLE: any partial divider count is discarded. Re-entering SCAN restarts from the current `x` with count 0.
- ACTIVE_LOW=1: `y` is the bitwise inverse of the active-high value in every state, including reset.
- Exactly one bit of `y` is active in DIRECT and SCAN. No bit is active in IDLE.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `idx`=0, divider count=0, `step`=0, `y`=0 (all ones if ACTIVE_LOW).
- Release is synchronous in effect: the first state update happens on the first rising edge with `rst_n`=1.
- Latency: inputs sampled on edge k appear on `y`/`idx` after edge k. This is one cycle, with no combinational input-to-output path.
- `en` falling: `y` goes inactive one cycle later. Reset asserted mid-scan forces outputs inactive immediately, without waiting for a clock edge.
- Scan period: each index is held for DIV cycles, except the entry index, which is also held DIV cycles. A full rotation is N·DIV cycles.
- `step` rises together with the `idx` change and is registered.

## Structure
- The shared package/header `decoder_pkg` holds:
  - state encodings IDLE=2'd0, DIRECT=2'd1, SCAN=2'd2
  - the `onehot` function (W → 2^W)
- Sub-module `tick_div` (parameter DIV): a clear/enable counter that outputs a terminal-count pulse. `decoder_scan` instantiates it once, with clear asserted whenever next state ≠ SCAN or on SCAN entry.
- Counter width is $clog2(DIV), with a minimum of 1 bit.

## Test plan
- Reset: with `rst_n`=0 asynchronously mid-cycle, `y`=4'b0000, `idx`=0, `step`=0 immediately. Repeat with ACTIVE_LOW=1 and expect `y`=4'b1111.
- Direct decode, W=2: `en`=1, `mode`=0, sweep `x`=0,1,2,3 → `y`=0001,0010,0100,1000 one cycle later. Then `en`=0 → `y`=0000 next cycle.
- Scan, W=2, DIV=3: enter with `x`=2.
  - Expected `y`=0100 for 3 cycles, then 1000 for 3 cycles, then 0001 (wrap) with `step` pulsing at each change.
  - Expected 4 pulses per 12 cycles.
- Scan, DIV=1, W=3: `y` rotates every cycle 00000001 → … → 10000000 → 00000001, with `step` held high.
- Mode switch mid-step: with DIV=4 in SCAN, after 2 count cycles switch to `mode`=0 with `x`=1 for one cycle, then back to SCAN with `x`=3.
  - Expected `y`=0010, then 1000 held a full 4 cycles.
  - Expected no `step` pulse on either transition.
- Reset mid-scan: assert `rst_n`=0 during SCAN at `idx`=2 → outputs inactive immediately. After release with `en`=1, `mode`=1, `x`=0, scan restarts at `idx`=0 with a fresh DIV count.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encodings and one-hot helper for decoder_scan
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Widest select the helper supports; callers truncate the result to 2^W bits.
    localparam int MAX_W = 8;
    localparam int MAX_N = 1 << MAX_W;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_W-1:0] sel);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - clear/enable modulo-DIV counter with terminal-count pulse
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : count enable
//   tc         : high while the count sits at DIV-1 and is enabled (wraps on this edge)
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tc = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered binary-to-one-hot decoder with auto-scan mode
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 1 = decoder active, 0 = all outputs inactive
//   mode       : 0 = direct decode of x, 1 = auto-scan
//   x          : direct select / scan start index
//   y          : registered one-hot (one-cold when ACTIVE_LOW) select
//   idx        : index currently asserted on y
//   step       : one-cycle pulse on each scan advance
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int W          = 2,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [W-1:0]         x,
    output logic [(1 << W)-1:0]  y,
    output logic [W-1:0]         idx,
    output logic                 step
);

    localparam int N = 1 << W;
    localparam logic [N-1:0] Y_OFF = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    state_t         state, state_nx;
    logic           clr, tc;
    logic [W-1:0]   idx_nx;
    logic           step_nx;
    logic           act_nx;
    logic [N-1:0]   y_hi, y_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        if (en) begin
            state_nx = mode ? SCAN : DIRECT;
        end
    end

    // The divider only runs across consecutive SCAN cycles; any exit or fresh
    // entry restarts it, so a partial count never leaks into the next scan.
    assign clr = (state_nx != SCAN) || (state != SCAN);

    tick_div #(
        .DIV(DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .en   (state_nx == SCAN),
        .tc   (tc)
    );

    always_comb begin
        idx_nx  = idx;
        step_nx = 1'b0;
        act_nx  = 1'b0;
        case (state_nx)
            DIRECT: begin
                idx_nx = x;
                act_nx = 1'b1;
            end
            SCAN: begin
                act_nx = 1'b1;
                if (state != SCAN) begin
                    idx_nx = x;
                end else if (tc) begin
                    idx_nx  = idx + 1'b1;
                    step_nx = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        y_hi = '0;
        if (act_nx) begin
            y_hi = N'(onehot(MAX_W'(idx_nx)));
        end
        y_nx = ACTIVE_LOW ? ~y_hi : y_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            step <= 1'b0;
            y    <= Y_OFF;
        end else begin
            idx  <= idx_nx;
            step <= step_nx;
            y    <= y_nx;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - self-checking bench for decoder_scan
module tb_decoder_scan;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       mode  = 1'b0;
    logic [2:0] x     = 3'd0;

    always #5 clk = ~clk;

    logic [3:0] ya, yb;
    logic [1:0] ia, ib;
    logic       sa, sb;
    logic [7:0] yc;
    logic [2:0] ic;
    logic       sc;

    decoder_scan #(.W(2), .DIV(3), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x[1:0]),
        .y(ya), .idx(ia), .step(sa));

    decoder_scan #(.W(2), .DIV(4), .ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x[1:0]),
        .y(yb), .idx(ib), .step(sb));

    decoder_scan #(.W(3), .DIV(1), .ACTIVE_LOW(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x),
        .y(yc), .idx(ic), .step(sc));

    int compared   = 0;
    int mismatched = 0;
    int pulses;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] y;
        logic [2:0] idx;
        logic       step;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] yexp(input int dut, input int i, input bit act);
        logic [7:0] v;
        v = act ? (8'd1 << i) : 8'd0;
        if (dut == 0) v = v & 8'h0F;
        if (dut == 1) v = ~v & 8'h0F;
        return v;
    endfunction

    task automatic push(input string tag, input int dut, input int i, input bit act, input bit st);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.y    = yexp(dut, i, act);
        e.idx  = 3'(i);
        e.step = st;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [7:0] oy;
        logic [2:0] oi;
        logic       os;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.dut)
                0:       begin oy = {4'b0, ya}; oi = {1'b0, ia}; os = sa; end
                1:       begin oy = {4'b0, yb}; oi = {1'b0, ib}; os = sb; end
                default: begin oy = yc;         oi = ic;         os = sc; end
            endcase
            chk({e.tag, ".y"},    oy,            e.y);
            chk({e.tag, ".idx"},  {5'b0, oi},    {5'b0, e.idx});
            chk({e.tag, ".step"}, {7'b0, os},    {7'b0, e.step});
        end
    endtask

    initial begin
        // asynchronous reset mid-cycle, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_a.y",    {4'b0, ya}, 8'h00);
        chk("rst_a.idx",  {6'b0, ia}, 8'h00);
        chk("rst_a.step", {7'b0, sa}, 8'h00);
        chk("rst_b.y",    {4'b0, yb}, 8'h0F);
        chk("rst_c.y",    yc,         8'h00);
        #10 rst_n = 1'b1;

        push("idle", 0, 0, 1'b0, 1'b0);
        tick();

        // direct decode sweep, then en falling
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 3'(i);
            push("dir_a", 0, i, 1'b1, 1'b0);
            push("dir_b", 1, i, 1'b1, 1'b0);
            tick();
        end
        en = 1'b0;
        push("en_off", 0, 3, 1'b0, 1'b0);
        tick();

        // scan DIV=3 from index 2, x changes after entry must be ignored
        en = 1'b1; mode = 1'b1; x = 3'd2;
        pulses = 0;
        for (int k = 1; k <= 13; k++) begin
            push("scan3", 0, (2 + (k - 1) / 3) % 4, 1'b1, (k > 1) && ((k - 1) % 3 == 0));
            tick();
            if (k >= 2) pulses += int'(sa);
            if (k == 1) x = 3'd0;
        end
        chk("scan3_pulses", 8'(pulses), 8'd4);

        // scan DIV=1, W=3: advance every cycle with step held high
        en = 1'b0;
        tick();
        x = 3'd0; en = 1'b1; mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push("scan1", 2, (k - 1) % 8, 1'b1, k > 1);
            tick();
        end

        // mode switch mid-step on DIV=4 active-low instance
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; x = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            push("msw_pre", 1, 0, 1'b1, 1'b0);
            tick();
        end
        mode = 1'b0; x = 3'd1;
        push("msw_dir", 1, 1, 1'b1, 1'b0);
        tick();
        mode = 1'b1; x = 3'd3;
        for (int k = 1; k <= 5; k++) begin
            push("msw_scan", 1, (k < 5) ? 3 : 0, 1'b1, k == 5);
            tick();
        end

        // reset mid-scan at idx 2, then restart from x=0 with a fresh count
        en = 1'b0;
        tick();
        x = 3'd1; en = 1'b1; mode = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push("pre_rst", 0, (k < 4) ? 1 : 2, 1'b1, k == 4);
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        chk("midrst.y",    {4'b0, ya}, 8'h00);
        chk("midrst.idx",  {6'b0, ia}, 8'h00);
        chk("midrst.step", {7'b0, sa}, 8'h00);
        chk("midrst_b.y",  {4'b0, yb}, 8'h0F);
        x = 3'd0;
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push("post_rst", 0, (k < 4) ? 0 : 1, 1'b1, k == 4);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "time limit expired");
    end

endmodule
